rsa_cmd_tx: RTL and testbench
=============================

Name: rsa_cmd_tx

Overview:
Host-side command transmitter for the RSA instruction channel. It accepts 16-bit plaintext instructions (opcode[15:10], operand[9:0]), encrypts each one as C = M^E mod N using a bit-serial square-and-multiply engine, and presents the ciphertext on a valid/ack link to the accelerator's Mi/i_valid/ack input. It is the transmitting end that produces the accelerator's encrypted input stream. Response decryption belongs to a separate receive block.

Parameters:
N, 16'd52961, RSA modulus; must be odd, 1 < N < 2^16.
E, 16'd19091, public exponent; it pairs with the accelerator's decryption exponent 11 under N = 211*251.
E_W, 16, number of exponent bits processed, 1..16; bits of E above E_W-1 are ignored.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
cmd_valid  in  1  plaintext command valid.
cmd_ready  out  1  block can accept a command.
cmd_data  in  16  plaintext instruction M.
tx_valid  out  1  ciphertext valid; drives the accelerator's i_valid.
tx_ack  in  1  ciphertext accepted; driven by the accelerator's ack.
tx_data  out  16  ciphertext C; drives Mi.
err  out  1  one-cycle pulse when a command is rejected because M >= N.
busy  out  1  high in any state except IDLE.

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous and active-high.
- State on reset: state = IDLE. acc, base, idx and the multiplier registers are cleared. tx_valid = 0, tx_data = 0, err = 0, busy = 0.
- cmd_ready = (state == IDLE) & ~rst. It is 0 while rst is asserted.
- Reset mid-operation aborts the current encryption immediately. The partial result is discarded and no tx_valid is produced.
- States: IDLE, LOAD, SQR, MUL, SEND.
- IDLE: a command is accepted when cmd_valid & cmd_ready at a rising edge.
  - If cmd_data >= N: err pulses for exactly the next cycle, the command is dropped, and the state stays IDLE.
  - Otherwise: base <= cmd_data, and the state goes to LOAD.
- LOAD (1 cycle): acc <= 1, idx <= E_W-1, then go to SQR.
- SQR (16 cycles): acc <= acc*acc mod N.
  - If E[idx] = 1, go to MUL.
  - Else, if idx == 0, go to SEND.
  - Else, decrement idx and go to SQR.
- MUL (16 cycles): acc <= acc*base mod N.
  - If idx == 0, go to SEND.
  - Else, decrement idx and go to SQR.
- Modular multiply (a*b mod N, shared by SQR and MUL):
  - Interleaved shift-add, one multiplier bit per cycle, MSB first, 16 cycles.
  - r starts at 0. Each step: r = 2r + (b[j] ? a : 0), computed 18 bits wide.
  - Then: if r >= 2N, subtract 2N; else if r >= N, subtract N.
  - Invariant r < N after every step; the final r is the product.
- SEND: tx_valid = 1 and tx_data = acc, both held stable until tx_ack is sampled high.
  - On tx_valid & tx_ack: next cycle tx_valid = 0 and state = IDLE, so cmd_ready = 1 one cycle after the handshake.
  - tx_ack while tx_valid = 0 is ignored.
- Latency: command accepted at edge k, tx_valid first high after edge k + 1 + 16*(E_W + popcount(E[E_W-1:0])). Default: 1 + 16*(16+7) = 369 cycles.
- Throughput: only one command is in flight at a time. No buffering.
- Boundary results: M = 0 gives C = 0. M = 1 gives C = 1. E = 0 gives C = 1.

Optional Feature:
RSA_TX_LZSKIP_EN: leading-zero skip.
- Defined: SQR phases are skipped while acc == 1 and no set exponent bit has been consumed yet. This covers zero bits above the highest set bit of E and the square at that highest set bit.
  - Latency = 1 + 16*(msb(E) + popcount(E)).
  - Default: 1 + 16*(14+7) = 337 cycles.
  - E = 0: LOAD goes straight to SEND, latency 1.
- Undefined: fixed-schedule latency as in Behaviour. Ciphertext values are identical in both builds.

Test Plan:
- Reset: assert rst with cmd_valid = 1 -> cmd_ready = 0, tx_valid = 0, err = 0. Release rst -> cmd_ready = 1.
- Defaults, cmd_data = 0, then 1, then 52960 -> tx_data = 0, 1, 52960 respectively (E odd). Each tx_valid arrives exactly 369 cycles after accept (337 with RSA_TX_LZSKIP_EN).
- E = 3, E_W = 2, cmd_data = 100 -> tx_data = 46702 after 65 cycles (49 with the skip build). cmd_data = 2 -> tx_data = 8.
- cmd_data = 52961 and cmd_data = 65535 -> err high for 1 cycle, no tx_valid, cmd_ready stays 1.
- Hold tx_ack = 0 for 20 cycles during SEND -> tx_valid and tx_data stable. Pulse tx_ack -> tx_valid drops next cycle and cmd_ready rises. A back-to-back second command is accepted that cycle.
- Assert rst during MUL -> no tx_valid. After release, a new command with cmd_data = 1 completes normally with tx_data = 1.

Source files
------------

// File: rtl/rsa_cmd_tx.sv
// rsa_cmd_tx: encrypts 16-bit commands as C = M^E mod N and presents them on a valid/ack link.
// Build macro RSA_TX_LZSKIP_EN enables leading-zero skip of the squarings before the first set exponent bit.
module rsa_cmd_tx #(
  parameter logic [15:0] N   = 16'd52961,
  parameter logic [15:0] E   = 16'd19091,
  parameter int unsigned E_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_data,
  output logic        tx_valid,
  input  logic        tx_ack,
  output logic [15:0] tx_data,
  output logic        err,
  output logic        busy
);
  localparam int unsigned W  = 16;
  localparam int unsigned RW = 18;
  localparam logic [W-1:0]  E_MASK  = (E_W >= W) ? '1 : W'((32'd1 << E_W) - 32'd1);
  localparam logic [W-1:0]  E_EFF   = E & E_MASK;
  localparam logic [3:0]    IDX_TOP = 4'(E_W - 1);
  localparam logic [RW-1:0] N_1     = {2'b00, N};
  localparam logic [RW-1:0] N_2     = {1'b0, N, 1'b0};

`ifdef RSA_TX_LZSKIP_EN
  function automatic logic [3:0] msb_idx(input logic [W-1:0] v);
    logic [3:0] m;
    m = '0;
    for (int i = 0; i < W; i++) if (v[i]) m = 4'(i);
    return m;
  endfunction
  localparam logic [3:0] IDX_MSB = msb_idx(E_EFF);
`endif

  typedef enum logic [2:0] {IDLE, LOAD, SQR, MUL, SEND} state_t;

  state_t        state, state_d;
  logic [W-1:0]  acc, acc_d, base, base_d, r, r_d, r_next, tx_data_d;
  logic [3:0]    idx, idx_d, cnt, cnt_d;
  logic [RW-1:0] r_sum;
  logic          mul_bit, phase_done, cmd_bad, err_d, tx_valid_d;

  assign cmd_ready  = (state == IDLE) & ~rst;
  assign busy       = (state != IDLE);
  assign cmd_bad    = (cmd_data >= N);
  assign phase_done = (cnt == 4'd15);

  // One MSB-first shift-add step of acc * (acc or base) mod N; r stays below N.
  always_comb begin
    mul_bit = (state == MUL) ? base[~cnt] : acc[~cnt];
    r_sum   = {1'b0, r, 1'b0} + (mul_bit ? {2'b00, acc} : '0);
    if (r_sum >= N_2)      r_next = W'(r_sum - N_2);
    else if (r_sum >= N_1) r_next = W'(r_sum - N_1);
    else                   r_next = W'(r_sum);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      base     <= '0;
      idx      <= '0;
      cnt      <= '0;
      r        <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_d;
      acc      <= acc_d;
      base     <= base_d;
      idx      <= idx_d;
      cnt      <= cnt_d;
      r        <= r_d;
      tx_valid <= tx_valid_d;
      tx_data  <= tx_data_d;
      err      <= err_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (cmd_valid && cmd_ready && !cmd_bad) state_d = LOAD;
      LOAD: begin
`ifdef RSA_TX_LZSKIP_EN
        // acc stays 1 through every square before the top set bit, so start at its multiply.
        state_d = (E_EFF == '0) ? SEND : MUL;
`else
        state_d = SQR;
`endif
      end
      SQR: begin
        if (phase_done) begin
          if (E_EFF[idx])     state_d = MUL;
          else if (idx == '0) state_d = SEND;
        end
      end
      MUL:  if (phase_done) state_d = (idx == '0) ? SEND : SQR;
      SEND: if (tx_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d  = acc;
    base_d = base;
    idx_d  = idx;
    cnt_d  = '0;
    r_d    = '0;
    err_d  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_bad) err_d  = 1'b1;
          else         base_d = cmd_data;
        end
      end
      LOAD: begin
        acc_d = W'(1);
`ifdef RSA_TX_LZSKIP_EN
        idx_d = IDX_MSB;
`else
        idx_d = IDX_TOP;
`endif
      end
      SQR, MUL: begin
        cnt_d = cnt + 4'd1;
        r_d   = phase_done ? '0 : r_next;
        if (phase_done) begin
          acc_d = r_next;
          // A square followed by its multiply keeps the same exponent index.
          if (idx != '0 && !(state == SQR && E_EFF[idx])) idx_d = idx - 4'd1;
        end
      end
      default: ;
    endcase
    tx_valid_d = (state_d == SEND);
    tx_data_d  = (state_d == SEND && state != SEND) ? acc_d : tx_data;
  end

endmodule

// File: tb/tb_rsa_cmd_tx.sv
// Directed bench for rsa_cmd_tx: default key, a tiny key (E=3, E_W=2) and an all-zero exponent.
module tb_rsa_cmd_tx;
`ifdef RSA_TX_LZSKIP_EN
  localparam int LAT_A = 337;
  localparam int LAT_B = 49;
  localparam int LAT_C = 1;
  localparam int RST_AT = 10;
`else
  localparam int LAT_A = 369;
  localparam int LAT_B = 65;
  localparam int LAT_C = 65;
  localparam int RST_AT = 40;
`endif

  logic clk = 1'b0;
  logic rst;
  logic a_cmd_valid, a_cmd_ready, a_tx_valid, a_tx_ack, a_err, a_busy;
  logic b_cmd_valid, b_cmd_ready, b_tx_valid, b_tx_ack, b_err, b_busy;
  logic c_cmd_valid, c_cmd_ready, c_tx_valid, c_tx_ack, c_err, c_busy;
  logic [15:0] a_cmd_data, a_tx_data, b_cmd_data, b_tx_data, c_cmd_data, c_tx_data;

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  always #5 clk = ~clk;

  rsa_cmd_tx u_a (
    .clk(clk), .rst(rst), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_data(a_cmd_data),
    .tx_valid(a_tx_valid), .tx_ack(a_tx_ack), .tx_data(a_tx_data), .err(a_err), .busy(a_busy));

  rsa_cmd_tx #(.N(16'd52961), .E(16'd3), .E_W(2)) u_b (
    .clk(clk), .rst(rst), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_data(b_cmd_data),
    .tx_valid(b_tx_valid), .tx_ack(b_tx_ack), .tx_data(b_tx_data), .err(b_err), .busy(b_busy));

  rsa_cmd_tx #(.N(16'd52961), .E(16'd0), .E_W(4)) u_c (
    .clk(clk), .rst(rst), .cmd_valid(c_cmd_valid), .cmd_ready(c_cmd_ready), .cmd_data(c_cmd_data),
    .tx_valid(c_tx_valid), .tx_ack(c_tx_ack), .tx_data(c_tx_data), .err(c_err), .busy(c_busy));

  function automatic logic f_valid(input int sel);
    return (sel == 0) ? a_tx_valid : (sel == 1) ? b_tx_valid : c_tx_valid;
  endfunction
  function automatic logic [15:0] f_data(input int sel);
    return (sel == 0) ? a_tx_data : (sel == 1) ? b_tx_data : c_tx_data;
  endfunction
  function automatic logic f_ready(input int sel);
    return (sel == 0) ? a_cmd_ready : (sel == 1) ? b_cmd_ready : c_cmd_ready;
  endfunction
  function automatic logic f_busy(input int sel);
    return (sel == 0) ? a_busy : (sel == 1) ? b_busy : c_busy;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [15:0] d);
    case (sel)
      0: begin a_cmd_valid = v; a_cmd_data = d; end
      1: begin b_cmd_valid = v; b_cmd_data = d; end
      default: begin c_cmd_valid = v; c_cmd_data = d; end
    endcase
  endtask

  task automatic set_ack(input int sel, input logic v);
    case (sel)
      0: a_tx_ack = v;
      1: b_tx_ack = v;
      default: c_tx_ack = v;
    endcase
  endtask

  // Present one command for exactly one rising edge.
  task automatic issue(input int sel, input logic [15:0] m);
    drive(sel, 1'b1, m);
    @(posedge clk); #1;
    drive(sel, 1'b0, m);
  endtask

  task automatic await_tx(input int sel, input int lat, input logic [15:0] c, input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!f_valid(sel) && n < 2000);
    check({tag, " latency"}, 32'(n), 32'(lat));
    check({tag, " data"}, 32'(f_data(sel)), 32'(c));
  endtask

  task automatic ack_tx(input int sel, input string tag);
    set_ack(sel, 1'b1);
    @(posedge clk); #1;
    set_ack(sel, 1'b0);
    check({tag, " valid drop"}, 32'(f_valid(sel)), 32'd0);
    check({tag, " ready back"}, 32'(f_ready(sel)), 32'd1);
  endtask

  initial begin
    logic seen;
    logic [15:0] m_bad [2];
    m_bad[0] = 16'd52961;
    m_bad[1] = 16'd65535;

    rst = 1'b1;
    drive(0, 1'b1, 16'd5);
    drive(1, 1'b0, 16'd0);
    drive(2, 1'b0, 16'd0);
    set_ack(0, 1'b0);
    set_ack(1, 1'b0);
    set_ack(2, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst cmd_ready", 32'(a_cmd_ready), 32'd0);
    check("rst tx_valid", 32'(a_tx_valid), 32'd0);
    check("rst err", 32'(a_err), 32'd0);
    check("rst busy", 32'(a_busy), 32'd0);
    check("rst tx_data", 32'(a_tx_data), 32'd0);
    drive(0, 1'b0, 16'd0);
    rst = 1'b0;
    #1;
    check("post-rst cmd_ready", 32'(a_cmd_ready), 32'd1);

    // Default key: fixed points 0, 1 and N-1 (E odd).
    issue(0, 16'd0);
    check("m0 busy", 32'(a_busy), 32'd1);
    await_tx(0, LAT_A, 16'd0, "m0");
    ack_tx(0, "m0");
    issue(0, 16'd1);
    await_tx(0, LAT_A, 16'd1, "m1");
    ack_tx(0, "m1");
    issue(0, 16'd52960);
    await_tx(0, LAT_A, 16'd52960, "mNm1");
    ack_tx(0, "mNm1");

    // Tiny key: 100^3 mod 52961 = 46702, 2^3 = 8.
    issue(1, 16'd100);
    await_tx(1, LAT_B, 16'd46702, "e3 m100");
    ack_tx(1, "e3 m100");
    issue(1, 16'd2);
    await_tx(1, LAT_B, 16'd8, "e3 m2");
    ack_tx(1, "e3 m2");

    // Zero exponent gives 1.
    issue(2, 16'd5);
    await_tx(2, LAT_C, 16'd1, "e0 m5");
    ack_tx(2, "e0 m5");

    // Out-of-range commands are rejected with a single err pulse.
    for (int i = 0; i < 2; i++) begin
      issue(0, m_bad[i]);
      check("bad err pulse", 32'(a_err), 32'd1);
      check("bad ready", 32'(a_cmd_ready), 32'd1);
      check("bad busy", 32'(a_busy), 32'd0);
      @(posedge clk); #1;
      check("bad err clear", 32'(a_err), 32'd0);
      seen = 1'b0;
      repeat (20) begin
        @(posedge clk); #1;
        if (a_tx_valid || a_err || !a_cmd_ready) seen = 1'b1;
      end
      check("bad quiet", 32'(seen), 32'd0);
    end

    // Back-pressure: hold output stable, then handshake and issue back-to-back.
    issue(1, 16'd3);
    await_tx(1, LAT_B, 16'd27, "hold m3");
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (b_tx_valid !== 1'b1 || b_tx_data !== 16'd27) seen = 1'b1;
    end
    check("hold stable", 32'(seen), 32'd0);
    ack_tx(1, "hold");
    issue(1, 16'd2);
    check("b2b accepted", 32'(b_busy), 32'd1);
    await_tx(1, LAT_B, 16'd8, "b2b m2");
    ack_tx(1, "b2b");

    // Reset during the first multiply phase aborts the encryption.
    issue(0, 16'd5);
    repeat (RST_AT) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check("abort tx_valid", 32'(a_tx_valid), 32'd0);
    check("abort busy", 32'(a_busy), 32'd0);
    check("abort cmd_ready", 32'(a_cmd_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (400) begin
      @(posedge clk); #1;
      if (a_tx_valid || a_busy) seen = 1'b1;
    end
    check("abort no tx", 32'(seen), 32'd0);
    issue(0, 16'd1);
    await_tx(0, LAT_A, 16'd1, "after abort m1");
    ack_tx(0, "after abort");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
